// File: rtl/sa_feeder.sv
// Operand feeder for an NxN output-stationary systolic array: clears the
// accumulators, streams K skewed A/B beats, drains with zeros, then pulses done.
module sa_feeder #(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  parameter int KMAX  = 16,
  parameter int KW    = $clog2(KMAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   a_col,
  input  logic [N*WIDTH-1:0]   b_row,
  output logic                 sa_en,
  output logic [N*WIDTH-1:0]   sa_a,
  output logic [N*WIDTH-1:0]   sa_b,
  output logic                 sa_clr_n,
  output logic                 done,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Drain counter only has to reach 2N-3.
  localparam int              DW         = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = (N > 1) ? DW'(2 * N - 3) : '0;
  localparam logic [KW-1:0]   KMAX_K     = KW'(KMAX);

  state_t          r_state;
  state_t          w_next;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   r_cnt;
  logic [DW-1:0]   r_dcnt;
  logic            r_sa_en;
  logic            r_clr_n;
  logic            r_done;

  logic            w_accept;
  logic            w_last_beat;
  logic            w_beat;
  logic            w_clear;
  logic            w_start_ok;
  logic            w_in_ready;
  logic            w_busy;

  // Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
  // in_ready is high only in FEED, and a_col/b_row must be stable while in_valid is high.
  assign w_accept    = (r_state == S_FEED) && in_valid;
  assign w_last_beat = w_accept && (r_cnt == (r_k - KW'(1)));
  assign w_beat      = w_accept || (r_state == S_DRAIN);
  assign w_clear     = (r_state == S_CLEAR);
  assign w_start_ok  = (r_state == S_IDLE) && start && (k_len != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_start_ok) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_next = S_FEED;
      end
      S_FEED: begin
        w_in_ready = 1'b1;
        if (w_last_beat) begin
          w_next = (N == 1) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_dcnt == DRAIN_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  // sa_clr_n is registered from the IDLE->CLEAR decision so it is low exactly
  // during the CLEAR cycle; done follows the DONE state, one cycle after the last sa_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_sa_en <= 1'b0;
      r_clr_n <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_sa_en <= w_beat;
      r_clr_n <= !w_start_ok;
      r_done  <= (r_state == S_DONE);
      if (w_start_ok) begin
        r_k <= (k_len > KMAX_K) ? KMAX_K : k_len;
      end
      if (w_clear) begin
        r_cnt  <= '0;
        r_dcnt <= '0;
      end else begin
        if (w_accept) begin
          r_cnt <= r_cnt + KW'(1);
        end
        if (r_state == S_DRAIN) begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;

    assign w_a_in = (r_state == S_FEED) ? a_col[gi*WIDTH +: WIDTH] : '0;
    assign w_b_in = (r_state == S_FEED) ? b_row[gi*WIDTH +: WIDTH] : '0;

    if (gi == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
          r_out_a <= '0;
          r_out_b <= '0;
        end else if (w_beat) begin
          r_out_a <= w_a_in;
          r_out_b <= w_b_in;
        end
      end
    end else begin : g_line
      // Entry d holds the beat from d+1 beats ago; the oldest feeds the output.
      logic [WIDTH-1:0] r_la [gi];
      logic [WIDTH-1:0] r_lb [gi];

      always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
          for (int d = 0; d < gi; d++) begin
            r_la[d] <= '0;
            r_lb[d] <= '0;
          end
          r_out_a <= '0;
          r_out_b <= '0;
        end else if (w_beat) begin
          r_la[0] <= w_a_in;
          r_lb[0] <= w_b_in;
          for (int d = 1; d < gi; d++) begin
            r_la[d] <= r_la[d-1];
            r_lb[d] <= r_lb[d-1];
          end
          r_out_a <= r_la[gi-1];
          r_out_b <= r_lb[gi-1];
        end
      end
    end

    assign sa_a[gi*WIDTH +: WIDTH] = r_out_a;
    assign sa_b[gi*WIDTH +: WIDTH] = r_out_b;
  end

  assign busy        = w_busy;
  assign in_ready    = w_in_ready;
  assign sa_en       = r_sa_en;
  assign sa_clr_n    = r_clr_n;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule
